// File: rtl/transmission_module_pkg.sv
// Shared definitions for the three-wire serial transmitter: FSM states and the
// minimum scl half-period that the receiver's input filter can tolerate.
package transmission_module_pkg;

    localparam int MIN_PRSCL = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_TAIL = 2'd3
    } tx_state_e;

endpackage

// File: rtl/transmission_module.sv
// Parallel-to-serial transmitter driving the en/sda/scl link MSB first, with a
// one-word pending buffer so consecutive words stream with en held high.
module transmission_module
    import transmission_module_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int PRSCL_WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic [DATA_WIDTH-1:0]  data_i,
    input  logic                   stb_i,
    input  logic [PRSCL_WIDTH-1:0] prscl_i,
    output logic                   ready_o,
    output logic                   busy_o,
    output logic                   en_o,
    output logic                   sda_o,
    output logic                   scl_o
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    tx_state_e              state;
    logic [PRSCL_WIDTH-1:0] cnt;
    logic [PRSCL_WIDTH-1:0] period;
    logic [PRSCL_WIDTH-1:0] p_eff;
    logic [IDX_W-1:0]       idx;
    logic [DATA_WIDTH-1:0]  shreg;
    logic [DATA_WIDTH-1:0]  pend_data;
    logic [DATA_WIDTH-1:0]  nxt_data;
    logic                   pend_vld;
    logic                   accept;
    logic                   half_done;
    logic                   nxt_vld;
    logic                   load_now;

    assign accept    = stb_i & ready_o;
    assign half_done = (cnt == '0);
    assign p_eff     = (prscl_i < PRSCL_WIDTH'(MIN_PRSCL)) ? PRSCL_WIDTH'(MIN_PRSCL) : prscl_i;

    // A word accepted on the very edge a frame ends goes straight to the shifter,
    // so it behaves exactly like a word that was already pending.
    assign nxt_vld  = pend_vld | accept;
    assign nxt_data = pend_vld ? pend_data : data_i;

    always_comb begin
        load_now = 1'b0;
        case (state)
            ST_IDLE: load_now = accept;
            ST_HIGH: load_now = half_done && (idx == '0) && nxt_vld;
            ST_TAIL: load_now = half_done && nxt_vld;
            default: load_now = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            period    <= '0;
            idx       <= '0;
            shreg     <= '0;
            pend_data <= '0;
            pend_vld  <= 1'b0;
            ready_o   <= 1'b1;
            busy_o    <= 1'b0;
            en_o      <= 1'b0;
            sda_o     <= 1'b0;
            scl_o     <= 1'b0;
        end else if (load_now) begin
            state  <= ST_LOW;
            shreg  <= nxt_data;
            sda_o  <= nxt_data[DATA_WIDTH-1];
            period <= p_eff;
            cnt    <= p_eff - PRSCL_WIDTH'(1);
            idx    <= IDX_W'(DATA_WIDTH - 1);
            en_o   <= 1'b1;
            busy_o <= 1'b1;
            scl_o  <= 1'b0;
            if (pend_vld) begin
                pend_vld <= 1'b0;
                ready_o  <= 1'b1;
            end
        end else begin
            if (accept) begin
                pend_data <= data_i;
                pend_vld  <= 1'b1;
                ready_o   <= 1'b0;
            end
            case (state)
                ST_LOW: begin
                    if (half_done) begin
                        state <= ST_HIGH;
                        scl_o <= 1'b1;
                        cnt   <= period - PRSCL_WIDTH'(1);
                    end else begin
                        cnt <= cnt - PRSCL_WIDTH'(1);
                    end
                end
                ST_HIGH: begin
                    if (!half_done) begin
                        cnt <= cnt - PRSCL_WIDTH'(1);
                    end else begin
                        scl_o <= 1'b0;
                        cnt   <= period - PRSCL_WIDTH'(1);
                        if (idx != '0) begin
                            state <= ST_LOW;
                            idx   <= idx - IDX_W'(1);
                            shreg <= shreg << 1;
                            sda_o <= shreg[DATA_WIDTH-2];
                        end else begin
                            state <= ST_TAIL;
                        end
                    end
                end
                ST_TAIL: begin
                    if (half_done) begin
                        state  <= ST_IDLE;
                        en_o   <= 1'b0;
                        busy_o <= 1'b0;
                        sda_o  <= 1'b0;
                    end else begin
                        cnt <= cnt - PRSCL_WIDTH'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_transmission_module.sv
// Bench for transmission_module: a link monitor decodes words from scl rises and
// is compared with the words the bench handed over and the expected frame timing.
module tb_transmission_module;

    localparam int DW = 8;
    localparam int PW = 8;

    logic          clk_i    = 1'b0;
    logic          reset_ni = 1'b0;
    logic [DW-1:0] data_i   = '0;
    logic          stb_i    = 1'b0;
    logic [PW-1:0] prscl_i  = '0;
    logic          ready_o, busy_o, en_o, sda_o, scl_o;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] rx_q[$];
    int            en_lens[$];
    int            rise_cyc[$];
    int            partials   = 0;
    int            sda_glitch = 0;
    int            cyc = 0, nbits = 0, en_run = 0;
    logic          prev_scl = 1'b0, prev_en = 1'b0, prev_sda = 1'b0;
    logic [DW-1:0] shw = '0;

    always #5 clk_i = ~clk_i;

    transmission_module #(.DATA_WIDTH(DW), .PRSCL_WIDTH(PW)) dut (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .data_i  (data_i),
        .stb_i   (stb_i),
        .prscl_i (prscl_i),
        .ready_o (ready_o),
        .busy_o  (busy_o),
        .en_o    (en_o),
        .sda_o   (sda_o),
        .scl_o   (scl_o)
    );

    // Receiver-side view of the link: sample sda on scl rises while en is high.
    always @(negedge clk_i) begin
        cyc++;
        if (!reset_ni) begin
            nbits = 0; en_run = 0; prev_scl = 1'b0; prev_en = 1'b0; prev_sda = 1'b0;
        end else begin
            if (en_o) en_run++;
            if (prev_en && !en_o) begin
                en_lens.push_back(en_run);
                en_run = 0;
                if (nbits != 0) partials++;
                nbits = 0;
            end
            if (en_o && scl_o && prev_scl && (sda_o !== prev_sda)) sda_glitch++;
            if (en_o && scl_o && !prev_scl) begin
                rise_cyc.push_back(cyc);
                shw = {shw[DW-2:0], sda_o};
                nbits++;
                if (nbits == DW) begin
                    rx_q.push_back(shw);
                    nbits = 0;
                end
            end
            prev_scl = scl_o; prev_en = en_o; prev_sda = sda_o;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, limit 500000", $time);
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        exp_q.delete(); rx_q.delete(); en_lens.delete(); rise_cyc.delete();
        partials = 0; sda_glitch = 0;
    endtask

    task automatic send(input logic [DW-1:0] w, input int p);
        int n = 0;
        @(negedge clk_i);
        data_i = w; prscl_i = PW'(p); stb_i = 1'b1;
        while (ready_o !== 1'b1 && n < 3000) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL send_timeout: ready_o=%b required 1 within 3000 cycles", ready_o);
        end
        @(posedge clk_i);
        #1 stb_i = 1'b0;
        exp_q.push_back(w);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while ((en_o !== 1'b0 || ready_o !== 1'b1) && n < 5000);
        checks++;
        if (n >= 5000) begin
            errors++;
            $display("FAIL idle_timeout: en_o=%b ready_o=%b required 0/1", en_o, ready_o);
        end
        repeat (3) @(negedge clk_i);
    endtask

    task automatic wait_rises(input int cnt);
        int n = 0;
        while (rise_cyc.size() < cnt && n < 3000) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL rise_timeout: saw %0d scl rises, required %0d", rise_cyc.size(), cnt);
        end
    endtask

    task automatic test_reset();
        reset_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if ({en_o, sda_o, scl_o, busy_o, ready_o} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_outputs: en/sda/scl/busy/ready=%b required 00001",
                     {en_o, sda_o, scl_o, busy_o, ready_o});
        end
        @(negedge clk_i);
        reset_ni = 1'b1;
        repeat (3) @(negedge clk_i);
        checks++;
        if ({en_o, scl_o, busy_o, ready_o} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_release: en/scl/busy/ready=%b required 0001",
                     {en_o, scl_o, busy_o, ready_o});
        end
    endtask

    task automatic test_single();
        logic [DW-1:0] w;
        clear_mon();
        w = 8'hA5;
        send(w, 4);
        @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b1 || en_o !== 1'b1 || sda_o !== w[DW-1]) begin
            errors++;
            $display("FAIL single_start: busy=%b en=%b sda=%b required 1 1 %b", busy_o, en_o, sda_o, w[DW-1]);
        end
        wait_idle();
        checks++;
        if (rise_cyc.size() !== DW) begin
            errors++;
            $display("FAIL single_rises: %0d required %0d", rise_cyc.size(), DW);
        end
        for (int i = 1; i < rise_cyc.size(); i++) begin
            checks++;
            if (rise_cyc[i] - rise_cyc[i-1] !== 8) begin
                errors++;
                $display("FAIL single_spacing: rise %0d gap %0d required 8", i, rise_cyc[i] - rise_cyc[i-1]);
            end
        end
        checks++;
        if (en_lens.size() !== 1 || en_lens[0] !== 2 * 4 * DW + 4) begin
            errors++;
            $display("FAIL single_en_len: frames=%0d len=%0d required 1 frame of %0d",
                     en_lens.size(), (en_lens.size() > 0) ? en_lens[0] : -1, 2 * 4 * DW + 4);
        end
        checks++;
        if (rx_q.size() !== 1 || rx_q[0] !== w || sda_glitch !== 0) begin
            errors++;
            $display("FAIL single_word: words=%0d first=%h glitches=%0d required 1 %h 0",
                     rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00, sda_glitch, w);
        end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        send(8'h3C, 4);
        repeat (10) @(negedge clk_i);
        send(8'hC3, 4);
        wait_idle();
        checks++;
        if (en_lens.size() !== 1 || rise_cyc.size() !== 2 * DW) begin
            errors++;
            $display("FAIL b2b_frame: en frames=%0d rises=%0d required 1 %0d", en_lens.size(), rise_cyc.size(), 2 * DW);
        end
        for (int i = 1; i < rise_cyc.size(); i++) begin
            checks++;
            if (rise_cyc[i] - rise_cyc[i-1] !== 8) begin
                errors++;
                $display("FAIL b2b_spacing: rise %0d gap %0d required 8", i, rise_cyc[i] - rise_cyc[i-1]);
            end
        end
        checks++;
        if (rx_q.size() !== 2) begin
            errors++;
            $display("FAIL b2b_count: %0d words required 2", rx_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (rx_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL b2b_word: idx %0d got %h required %h", i, rx_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_prescale();
        int plist[3];
        int pe[3];
        plist = '{0, 10, 7};
        pe    = '{4, 10, 7};
        for (int t = 0; t < 3; t++) begin
            clear_mon();
            send(DW'($urandom), plist[t]);
            prscl_i = PW'($urandom_range(0, 20)); // mid-word change must be ignored
            wait_idle();
            checks++;
            if (en_lens.size() !== 1 || en_lens[0] !== 2 * pe[t] * DW + pe[t]) begin
                errors++;
                $display("FAIL prscl_en_len: prscl=%0d len=%0d required %0d", plist[t],
                         (en_lens.size() > 0) ? en_lens[0] : -1, 2 * pe[t] * DW + pe[t]);
            end
            for (int i = 1; i < rise_cyc.size(); i++) begin
                checks++;
                if (rise_cyc[i] - rise_cyc[i-1] !== 2 * pe[t]) begin
                    errors++;
                    $display("FAIL prscl_spacing: prscl=%0d gap %0d required %0d", plist[t],
                             rise_cyc[i] - rise_cyc[i-1], 2 * pe[t]);
                end
            end
            checks++;
            if (rx_q.size() !== 1 || rx_q[0] !== exp_q[0]) begin
                errors++;
                $display("FAIL prscl_word: prscl=%0d words=%0d got %h required %h", plist[t], rx_q.size(),
                         (rx_q.size() > 0) ? rx_q[0] : 8'h00, exp_q[0]);
            end
        end
    endtask

    task automatic test_stream();
        clear_mon();
        send(DW'($urandom), 4);
        send(DW'($urandom), 4);
        @(negedge clk_i);
        checks++;
        if (ready_o !== 1'b0) begin
            errors++;
            $display("FAIL stream_ready: ready_o=%b required 0 with a word pending", ready_o);
        end
        send(DW'($urandom), 4);
        wait_idle();
        checks++;
        if (en_lens.size() !== 1 || rise_cyc.size() !== 3 * DW || sda_glitch !== 0) begin
            errors++;
            $display("FAIL stream_frame: frames=%0d rises=%0d glitches=%0d required 1 %0d 0",
                     en_lens.size(), rise_cyc.size(), sda_glitch, 3 * DW);
        end
        checks++;
        if (rx_q.size() !== 3) begin
            errors++;
            $display("FAIL stream_count: %0d words required 3", rx_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (rx_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL stream_word: idx %0d got %h required %h", i, rx_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_tail_accept();
        clear_mon();
        send(DW'($urandom), 8);
        wait_rises(DW);
        repeat (8 + 1) @(negedge clk_i);
        send(DW'($urandom), 8);
        wait_idle();
        checks++;
        if (en_lens.size() !== 1 || en_lens[0] <= 2 * 8 * DW + 8) begin
            errors++;
            $display("FAIL tail_en: frames=%0d len=%0d required 1 frame longer than %0d", en_lens.size(),
                     (en_lens.size() > 0) ? en_lens[0] : -1, 2 * 8 * DW + 8);
        end
        checks++;
        if (rx_q.size() !== 2 || rx_q[0] !== exp_q[0] || rx_q[1] !== exp_q[1]) begin
            errors++;
            $display("FAIL tail_words: count=%0d got %h %h required %h %h", rx_q.size(),
                     (rx_q.size() > 0) ? rx_q[0] : 8'h00, (rx_q.size() > 1) ? rx_q[1] : 8'h00, exp_q[0], exp_q[1]);
        end
    endtask

    task automatic test_mid_reset();
        clear_mon();
        send(8'h5A, 4);
        wait_rises(3);
        @(negedge clk_i);
        reset_ni = 1'b0;
        #1;
        checks++;
        if ({en_o, sda_o, scl_o, busy_o, ready_o} !== 5'b00001) begin
            errors++;
            $display("FAIL midreset_outputs: en/sda/scl/busy/ready=%b required 00001",
                     {en_o, sda_o, scl_o, busy_o, ready_o});
        end
        repeat (2) @(negedge clk_i);
        reset_ni = 1'b1;
        @(negedge clk_i);
        checks++;
        if (ready_o !== 1'b1 || rx_q.size() !== 0 || partials !== 0) begin
            errors++;
            $display("FAIL midreset_abort: ready=%b words=%0d partials=%0d required 1 0 0", ready_o, rx_q.size(), partials);
        end
        exp_q.delete();
        send(8'hFF, 4);
        wait_idle();
        checks++;
        if (rx_q.size() !== 1 || rx_q[0] !== 8'hFF) begin
            errors++;
            $display("FAIL midreset_next: words=%0d got %h required 1 ff", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00);
        end
    endtask

    task automatic test_random();
        clear_mon();
        for (int k = 0; k < 8; k++) begin
            send(DW'($urandom), $urandom_range(0, 12));
            repeat ($urandom_range(0, 120)) @(negedge clk_i);
        end
        wait_idle();
        checks++;
        if (rx_q.size() !== exp_q.size() || partials !== 0 || sda_glitch !== 0) begin
            errors++;
            $display("FAIL random_count: words=%0d partials=%0d glitches=%0d required %0d 0 0",
                     rx_q.size(), partials, sda_glitch, exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (rx_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL random_word: idx %0d got %h required %h", i, rx_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_prescale();
        test_stream();
        test_tail_accept();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
